// File: rtl/stepper_move_seq_pkg.sv
// Shared types for the stepper move sequencer: FSM state, segment record, defaults.
// Stepper field widths come from the STEPPER_* macros when the integration defines them.
`ifndef STEPPER_PULSE_NUM_X_BITS
`define STEPPER_PULSE_NUM_X_BITS 16
`endif
`ifndef STEPPER_PULSE_NUM_Y_BITS
`define STEPPER_PULSE_NUM_Y_BITS 16
`endif
`ifndef STEPPER_PULSE_WIDTH_BITS
`define STEPPER_PULSE_WIDTH_BITS 16
`endif
`ifndef STEPPER_PULSE_WIDTH
`define STEPPER_PULSE_WIDTH 10
`endif

package stepper_move_seq_pkg;

    localparam int PNX_BITS        = `STEPPER_PULSE_NUM_X_BITS;
    localparam int PNY_BITS        = `STEPPER_PULSE_NUM_Y_BITS;
    localparam int PW_BITS         = `STEPPER_PULSE_WIDTH_BITS;
    localparam int SEG_MAX_DEFAULT = 127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PLAN,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } move_seq_state_t;

    typedef struct packed {
        logic signed [PNX_BITS-1:0] pulse_num_x;
        logic signed [PNY_BITS-1:0] pulse_num_y;
    } move_seg_t;

    function automatic int apply_sign(input int mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/StepperCtrlXY_IF.sv
// Handshake bundle between the move sequencer (master) and the XY stepper controller.
`ifndef STEPPER_PULSE_NUM_X_BITS
`define STEPPER_PULSE_NUM_X_BITS 16
`endif
`ifndef STEPPER_PULSE_NUM_Y_BITS
`define STEPPER_PULSE_NUM_Y_BITS 16
`endif
`ifndef STEPPER_PULSE_WIDTH_BITS
`define STEPPER_PULSE_WIDTH_BITS 16
`endif

interface StepperCtrlXY_IF;
    logic                                        trigger;
    logic signed [`STEPPER_PULSE_NUM_X_BITS-1:0] pulse_num_x;
    logic signed [`STEPPER_PULSE_NUM_Y_BITS-1:0] pulse_num_y;
    logic [`STEPPER_PULSE_WIDTH_BITS-1:0]        pulse_width;
    logic                                        done;
    logic                                        rdy;

    modport master (
        output trigger, pulse_num_x, pulse_num_y, pulse_width,
        input  done, rdy
    );

    modport slave (
        input  trigger, pulse_num_x, pulse_num_y, pulse_width,
        output done, rdy
    );
endinterface

// File: rtl/move_seg_planner.sv
// Bresenham segment planner: one major-axis step per cycle, emits segments of at most
// SEG_MAX major pulses into a one-entry buffer drained by the issuer via consume.
module move_seg_planner
    import stepper_move_seq_pkg::*;
#(
    parameter int CMD_BITS = 16,
    parameter int SEG_MAX  = SEG_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                flush,
    input  logic                consume,
    input  logic [CMD_BITS-1:0] major,
    input  logic [CMD_BITS-1:0] minor,
    input  logic                major_is_x,
    input  logic                neg_x,
    input  logic                neg_y,
    output logic                seg_valid,
    output logic                none_left,
    output move_seg_t           seg
);
    localparam int SEG_W = $clog2(SEG_MAX + 1);

    logic signed [CMD_BITS:0] err_q, err_d;
    logic signed [CMD_BITS:0] err_sub, err_major;
    logic [CMD_BITS-1:0]      remaining_q, remaining_d;
    logic [SEG_W-1:0]         steps_q, steps_d, steps_next;
    logic [SEG_W-1:0]         minor_cnt_q, minor_cnt_d, cnt_next;
    logic                     buf_valid_q, buf_valid_d;
    move_seg_t                buf_q, buf_d;
    logic                     borrow, seg_end, step_en;

    function automatic move_seg_t pack_seg(input logic [SEG_W-1:0] maj_n,
                                           input logic [SEG_W-1:0] min_n,
                                           input logic             maj_x,
                                           input logic             nx,
                                           input logic             ny);
        move_seg_t s;
        int        mx;
        int        my;
        mx = maj_x ? int'(maj_n) : int'(min_n);
        my = maj_x ? int'(min_n) : int'(maj_n);
        s.pulse_num_x = PNX_BITS'(apply_sign(mx, nx));
        s.pulse_num_y = PNY_BITS'(apply_sign(my, ny));
        return s;
    endfunction

    assign err_major  = $signed({1'b0, major});
    assign err_sub    = err_q - $signed({1'b0, minor});
    assign borrow     = err_sub[CMD_BITS];
    assign steps_next = steps_q + SEG_W'(1);
    assign cnt_next   = minor_cnt_q + SEG_W'(borrow);
    assign seg_end    = (steps_q == SEG_W'(SEG_MAX - 1)) || (remaining_q == CMD_BITS'(1));
    // A step that closes a segment must wait until the buffer has room for it.
    assign step_en    = (remaining_q != '0) && !(seg_end && buf_valid_q);

    always_comb begin
        err_d       = err_q;
        remaining_d = remaining_q;
        steps_d     = steps_q;
        minor_cnt_d = minor_cnt_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;

        if (consume) begin
            buf_valid_d = 1'b0;
        end

        if (step_en) begin
            remaining_d = remaining_q - CMD_BITS'(1);
            err_d       = borrow ? (err_sub + err_major) : err_sub;
            if (seg_end) begin
                buf_valid_d = 1'b1;
                buf_d       = pack_seg(steps_next, cnt_next, major_is_x, neg_x, neg_y);
                steps_d     = '0;
                minor_cnt_d = '0;
            end else begin
                steps_d     = steps_next;
                minor_cnt_d = cnt_next;
            end
        end

        if (start) begin
            err_d       = $signed({2'b00, major[CMD_BITS-1:1]});
            remaining_d = major;
            steps_d     = '0;
            minor_cnt_d = '0;
            buf_valid_d = 1'b0;
        end

        if (flush) begin
            remaining_d = '0;
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining_q <= '0;
            steps_q     <= '0;
            minor_cnt_q <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            steps_q     <= steps_d;
            minor_cnt_q <= minor_cnt_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        err_q <= err_d;
        buf_q <= buf_d;
    end

    assign seg_valid = buf_valid_q;
    assign seg       = buf_q;
    assign none_left = (remaining_q == '0) && !buf_valid_q;

endmodule

// File: rtl/stepper_move_seq.sv
// Move sequencer: splits a signed (dx, dy) move into straight segments and feeds them to
// StepperCtrlXY one handshake at a time. Optional abort input: STEPPER_MOVE_SEQ_ABORT_EN.
module stepper_move_seq
    import stepper_move_seq_pkg::*;
#(
    parameter int CMD_BITS    = 16,
    parameter int SEG_MAX     = SEG_MAX_DEFAULT,
    parameter int PULSE_WIDTH = `STEPPER_PULSE_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_rdy,
    input  logic signed [CMD_BITS-1:0] cmd_dx,
    input  logic signed [CMD_BITS-1:0] cmd_dy,
    StepperCtrlXY_IF.master            stepper,
    output logic                       busy,
    output logic                       move_done
`ifdef STEPPER_MOVE_SEQ_ABORT_EN
    ,
    input  logic                       abort
`endif
);
    move_seq_state_t            state_q, state_d;
    logic [CMD_BITS-1:0]        abs_x_q, abs_x_d, abs_y_q, abs_y_d;
    logic                       neg_x_q, neg_x_d, neg_y_q, neg_y_d;
    logic                       abort_pend_q, abort_pend_d;
    logic signed [PNX_BITS-1:0] pulse_num_x_q, pulse_num_x_d;
    logic signed [PNY_BITS-1:0] pulse_num_y_q, pulse_num_y_d;
    logic                       accept, abort_i;
    logic                       plan_start, plan_flush, seg_consume;
    logic                       seg_valid, none_left, major_is_x;
    logic [CMD_BITS-1:0]        major, minor;
    move_seg_t                  seg;

    function automatic logic [CMD_BITS-1:0] abs_val(input logic signed [CMD_BITS-1:0] v);
        // The most negative value maps onto 2^(CMD_BITS-1), still representable unsigned.
        return v[CMD_BITS-1] ? CMD_BITS'(-v) : CMD_BITS'(v);
    endfunction

`ifdef STEPPER_MOVE_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign accept     = (state_q == ST_IDLE) && cmd_valid;
    assign major_is_x = (abs_x_q >= abs_y_q);
    assign major      = major_is_x ? abs_x_q : abs_y_q;
    assign minor      = major_is_x ? abs_y_q : abs_x_q;

    always_comb begin
        abs_x_d = abs_x_q;
        abs_y_d = abs_y_q;
        neg_x_d = neg_x_q;
        neg_y_d = neg_y_q;
        if (accept) begin
            abs_x_d = abs_val(cmd_dx);
            abs_y_d = abs_val(cmd_dy);
            neg_x_d = cmd_dx[CMD_BITS-1];
            neg_y_d = cmd_dy[CMD_BITS-1];
        end
    end

    always_comb begin
        state_d       = state_q;
        abort_pend_d  = abort_pend_q;
        pulse_num_x_d = pulse_num_x_q;
        pulse_num_y_d = pulse_num_y_q;
        plan_start    = 1'b0;
        plan_flush    = 1'b0;
        seg_consume   = 1'b0;
        move_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                plan_start = 1'b1;
                if (abort_i) begin
                    plan_flush = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_PLAN;
                end
            end
            ST_PLAN: begin
                if (abort_i) begin
                    plan_flush = 1'b1;
                    state_d    = ST_IDLE;
                end else if (seg_valid) begin
                    seg_consume   = 1'b1;
                    pulse_num_x_d = seg.pulse_num_x;
                    pulse_num_y_d = seg.pulse_num_y;
                    state_d       = ST_ISSUE;
                end else if (none_left) begin
                    state_d = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
                if (!stepper.done) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
                // Next segment is issued only once the controller reports ready again.
                if (stepper.rdy) begin
                    if (abort_pend_q || abort_i) begin
                        plan_flush = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (seg_valid) begin
                        seg_consume   = 1'b1;
                        pulse_num_x_d = seg.pulse_num_x;
                        pulse_num_y_d = seg.pulse_num_y;
                        state_d       = ST_ISSUE;
                    end else if (none_left) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                move_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            abort_pend_q  <= 1'b0;
            pulse_num_x_q <= '0;
            pulse_num_y_q <= '0;
        end else begin
            state_q       <= state_d;
            abort_pend_q  <= abort_pend_d;
            pulse_num_x_q <= pulse_num_x_d;
            pulse_num_y_q <= pulse_num_y_d;
        end
    end

    always_ff @(posedge clk) begin
        abs_x_q <= abs_x_d;
        abs_y_q <= abs_y_d;
        neg_x_q <= neg_x_d;
        neg_y_q <= neg_y_d;
    end

    move_seg_planner #(
        .CMD_BITS (CMD_BITS),
        .SEG_MAX  (SEG_MAX)
    ) u_planner (
        .clk        (clk),
        .reset      (reset),
        .start      (plan_start),
        .flush      (plan_flush),
        .consume    (seg_consume),
        .major      (major),
        .minor      (minor),
        .major_is_x (major_is_x),
        .neg_x      (neg_x_q),
        .neg_y      (neg_y_q),
        .seg_valid  (seg_valid),
        .none_left  (none_left),
        .seg        (seg)
    );

    assign cmd_rdy             = (state_q == ST_IDLE);
    assign busy                = (state_q != ST_IDLE);
    assign stepper.trigger     = (state_q == ST_ISSUE);
    assign stepper.pulse_num_x = pulse_num_x_q;
    assign stepper.pulse_num_y = pulse_num_y_q;
    assign stepper.pulse_width = PW_BITS'(PULSE_WIDTH);

endmodule

// File: doc/stepper_move_seq.md
# stepper_move_seq

Move sequencer in front of `StepperCtrlXY`. Accepts one signed relative move (dx, dy) from the command decoder, splits it into line segments no longer than `SEG_MAX` pulses on the major axis, and distributes minor-axis pulses by Bresenham accumulation so the path stays straight. It drives the stepper controller's master handshake one segment at a time and plans the next segment while the current one executes.

## Interface
- `CMD_BITS`, 16: width of signed `cmd_dx` and `cmd_dy`.
- `SEG_MAX`, 127: maximum major-axis pulses per segment; must be ≤ 2^(`STEPPER_PULSE_NUM_X_BITS`-1)-1 and ≤ 2^(`STEPPER_PULSE_NUM_Y_BITS`-1)-1.
- `PULSE_WIDTH`, `STEPPER_PULSE_WIDTH`: constant driven on `stepper.pulse_width`.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `cmd_valid`  in  1  move command present.
- `cmd_rdy`  out  1  sequencer idle; command accepted on `cmd_valid & cmd_rdy`.
- `cmd_dx`, `cmd_dy`  in  `CMD_BITS`  signed relative move.
- `stepper`  master modport of `StepperCtrlXY_IF`: drives trigger, pulse_num_x, pulse_num_y, pulse_width; samples done, rdy.
- `busy`  out  1  move in progress.
- `move_done`  out  1  one-cycle pulse when the last segment completes.
- `abort`  in  1  only with `STEPPER_MOVE_SEQ_ABORT_EN` (see Configuration).

## Operation
- Accept: latch signs, `|dx|`, `|dy|`. Major = x if `|dx| ≥ |dy|` (tie → x), else y. `err` = floor(major/2), `remaining` = major.
- Planner, per major step (one cycle each): `err -= minor`; if `err < 0` then `err += major`, `minor_cnt++`. A segment ends after min(`SEG_MAX`, `remaining`) steps. Output (`seg_major`, `minor_cnt`) with latched signs applied, mapped back onto x/y.
- `err` is signed, `CMD_BITS+1` bits; `|cmd_*|` uses `CMD_BITS` unsigned, so -2^(CMD_BITS-1) is legal.
- One-entry segment buffer between planner and issuer. The planner fills it while the issuer waits on `rdy`.
- Issuer FSM: IDLE → SETUP → PLAN → ISSUE → WAIT → (ISSUE | DONE) → IDLE.
  - ISSUE: present buffered pulse_num_x/y, `trigger=1`, hold until `done==0`.
  - WAIT: `trigger=0`, hold until `rdy==1`. If a buffered segment exists, go to ISSUE. If none remain, go to DONE. Otherwise stay until the planner fills the buffer.
  - DONE: `move_done=1` for one cycle.
- Zero move (dx=dy=0): no trigger; `move_done` 3 cycles after accept.
- `cmd_valid` while busy is ignored; `cmd_rdy` stays 0.

## Timing
- Reset values: `trigger=0`, `pulse_num_x=0`, `pulse_num_y=0`, `cmd_rdy=1`, `busy=0`, `move_done=0`. FSM = IDLE, buffer empty.
- `cmd_rdy` and `busy` change the cycle after accept.
- First `trigger` rises SETUP(1) + PLAN(n) + 1 cycles after accept, where n is the first segment's major length.
- pulse_num_x/y are stable from `trigger` rising until `done==0` is seen.
- Between segments, `trigger` rises the cycle after `rdy==1` when the buffer is full.
- Reset asserted mid-move: all outputs go to reset values immediately; the stepper is not re-triggered.

## Configuration
- `STEPPER_MOVE_SEQ_ABORT_EN` defined: adds `abort` input.
  - `abort` in PLAN or SETUP: go to IDLE next cycle.
  - `abort` in ISSUE or WAIT: stop issuing, finish the current handshake (wait `rdy==1`), then go to IDLE.
  - No `move_done` on abort.
- Not defined: no `abort` port; every move runs to completion.

## Structure
- Shared package gets the FSM state enum `move_seq_state_t`, the segment struct {pulse_num_x, pulse_num_y}, and the default `SEG_MAX`.
- Sub-module `move_seg_planner`: Bresenham accumulator plus segment counter, with a start/valid/consume handshake to the issuer.

## Test plan
- dx=3, dy=0 → one segment (3,0); `move_done` after `rdy`; exactly one trigger.
- dx=300, dy=100 → segments (127,42), (127,43), (46,15); sums 300/100.
- dx=-300, dy=100 → segments (-127,42), (-127,43), (-46,15).
- dx=0, dy=-2 → one segment (0,-2). dx=dy=0 → no trigger, `move_done` pulse.
- `cmd_valid` during a move is ignored. Reset mid-WAIT → `trigger=0`, `cmd_rdy=1` immediately.
- With `STEPPER_MOVE_SEQ_ABORT_EN`: abort during the second segment of dx=300 → that segment's handshake finishes, no third trigger, no `move_done`.
